// File: rtl/mul_bram_stream_ctrl.sv
// rtl/mul_bram_stream_ctrl.sv - buffers a pass of wide words, then replays each as mode+1 narrow beats
module mul_bram_stream_ctrl #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int IN_W  = 256,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = LANES * DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     cfg_len,
  input  logic [1:0]      mode,
  input  logic [IN_W-1:0] interface_in,
  input  logic            input_vld,
  output logic            input_ready,
  output logic [BW-1:0]   interface_out,
  output logic            output_vld,
  input  logic            output_ready,
  output logic [1:0]      state,
  output logic            stop,
  output logic            clamped
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {PH_WAIT, PH_LATCH, PH_BEAT} phase_t;

  localparam int          LW      = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(DEPTH);

  state_t          st;
  phase_t          phase;
  logic [1:0]      rst_sync;
  logic            rst_n_i;
  logic [IN_W-1:0] mem [DEPTH];
  logic [IN_W-1:0] mem_q;
  logic [IN_W-1:0] word_reg;
  logic [BW-1:0]   next_slice;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     len_q;
  logic [1:0]      mode_q;
  logic [1:0]      beat_cnt;
  logic [1:0]      next_beat;
  logic            wr_en;

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign state      = st;
  assign wr_en      = (st == S_LOAD) && input_vld && input_ready;
  assign next_beat  = beat_cnt + 2'd1;
  assign next_slice = BW'(word_reg >> (32'(next_beat) * BW));

  // The read port runs every cycle so the next word is already waiting when a word's beats finish.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= interface_in;
    mem_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st            <= S_IDLE;
      phase         <= PH_WAIT;
      input_ready   <= 1'b0;
      output_vld    <= 1'b0;
      interface_out <= '0;
      stop          <= 1'b0;
      clamped       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len_q         <= '0;
      mode_q        <= '0;
      beat_cnt      <= '0;
      word_reg      <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start && cfg_len != '0) begin
            st          <= S_LOAD;
            input_ready <= 1'b1;
            len_q       <= (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
            clamped     <= (cfg_len > DEPTH_L);
            mode_q      <= mode;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
          end
        end
        S_LOAD: begin
          if (input_vld && input_ready) begin
            wr_ptr <= wr_ptr + LW'(1);
            if (wr_ptr + LW'(1) == len_q) begin
              input_ready <= 1'b0;
              st          <= S_RUN;
              phase       <= PH_WAIT;
            end
          end
        end
        S_RUN: begin
          case (phase)
            PH_WAIT: phase <= PH_LATCH;
            PH_LATCH: begin
              word_reg      <= mem_q;
              interface_out <= mem_q[BW-1:0];
              output_vld    <= 1'b1;
              beat_cnt      <= '0;
              rd_ptr        <= rd_ptr + LW'(1);
              phase         <= PH_BEAT;
            end
            default: begin
              if (output_ready) begin
                if (beat_cnt == mode_q) begin
                  output_vld <= 1'b0;
                  if (rd_ptr == len_q) begin
                    st   <= S_DONE;
                    stop <= 1'b1;
                  end else begin
                    phase <= PH_LATCH;
                  end
                end else begin
                  beat_cnt      <= next_beat;
                  interface_out <= next_slice;
                end
              end
            end
          endcase
        end
        default: begin
          if (!start) begin
            st   <= S_IDLE;
            stop <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_bram_stream_ctrl.sv
// tb/tb_mul_bram_stream_ctrl.sv - randomized directed bench with a queue-based beat model
module tb_mul_bram_stream_ctrl;
  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int IN_W  = 256;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int BW    = DW * LANES;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [AW:0]     cfg_len = '0;
  logic [1:0]      mode = '0;
  logic [IN_W-1:0] interface_in = '0;
  logic            input_vld = 1'b0;
  logic            input_ready;
  logic [BW-1:0]   interface_out;
  logic            output_vld;
  logic            output_ready = 1'b0;
  logic [1:0]      state;
  logic            stop;
  logic            clamped;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mul_bram_stream_ctrl #(.DW(DW), .LANES(LANES), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .mode(mode),
    .interface_in(interface_in), .input_vld(input_vld), .input_ready(input_ready),
    .interface_out(interface_out), .output_vld(output_vld), .output_ready(output_ready),
    .state(state), .stop(stop), .clamped(clamped)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] r = '0;
    for (int i = 0; i < IN_W / 32; i++) r = {r[IN_W-33:0], 32'($urandom)};
    return r;
  endfunction

  // One full pass; abort_after > 0 pulls reset right after that many beats are accepted.
  task automatic run_pass(input int len, input int md, input int rdy_pat, input int abort_after);
    logic [IN_W-1:0] words[$];
    logic [BW-1:0]   exp_q[$];
    logic [IN_W-1:0] tmp;
    int eff, bpw, nbeats, acc, beats, cyc, t, pend;
    bit stalled, first_pending, extra_ready;
    eff    = (len > DEPTH) ? DEPTH : len;
    bpw    = md + 1;
    nbeats = eff * bpw;
    for (int w = 0; w < len; w++) words.push_back(rand_word());
    for (int w = 0; w < eff; w++) begin
      tmp = words[w];
      for (int k = 0; k < bpw; k++) exp_q.push_back(tmp[k*BW +: BW]);
    end

    cfg_len = LW'(len);
    mode    = md[1:0];
    start   = 1'b1;
    cyc     = 0;
    while (state !== 2'b01 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("enter_load", state, 2'b01);
    check("clamped", clamped, len > DEPTH);
    cfg_len = LW'($urandom);
    mode    = 2'($urandom);

    acc = 0;
    cyc = 0;
    while (acc < eff && cyc < 4 * DEPTH + 20) begin
      input_vld    = ($urandom_range(0, 3) != 0);
      interface_in = words[acc];
      if (input_vld && input_ready) acc++;
      tick();
      cyc++;
    end
    check("load_count", acc, eff);
    check("ready_drop", input_ready, 1'b0);
    check("enter_run", state, 2'b10);
    input_vld    = 1'b1;
    interface_in = rand_word();

    beats = 0; t = 0; pend = 0;
    stalled = 1'b0; first_pending = 1'b1; extra_ready = 1'b0;
    while (beats < nbeats && t < 8 * nbeats + 20) begin
      if (rdy_pat == 0)      output_ready = 1'b1;
      else if (rdy_pat == 1) output_ready = ~output_ready;
      else                   output_ready = 1'($urandom_range(0, 1));
      if (input_ready) extra_ready = 1'b1;
      if (first_pending && output_vld) begin
        check("first_vld_lat", t, 2);
        first_pending = 1'b0;
      end
      case (pend)
        1: check("beat_no_gap", output_vld, 1'b1);
        2: check("word_gap", output_vld, 1'b0);
        3: check("word_resume", output_vld, 1'b1);
        default: ;
      endcase
      pend = (pend == 2) ? 3 : 0;
      if (stalled) check("stall_hold", output_vld, 1'b1);
      if (output_vld) begin
        if (exp_q.size() > 0) check("beat_data", interface_out, exp_q[0]);
        else                  check("beat_excess", output_vld, 1'b0);
      end
      stalled = output_vld && !output_ready;
      if (output_vld && output_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats++;
        pend = (beats == nbeats) ? 4 : ((beats % bpw) != 0) ? 1 : 2;
        if (abort_after != 0 && beats == abort_after) begin
          tick();
          rst = 1'b0;
          #1;
          check("abort_vld", output_vld, 1'b0);
          check("abort_state", state, 2'b00);
          check("abort_dout", interface_out, '0);
          check("abort_clamped", clamped, 1'b0);
          check("abort_in_rdy", input_ready, 1'b0);
          input_vld    = 1'b0;
          output_ready = 1'b0;
          start        = 1'b0;
          return;
        end
      end
      tick();
      t++;
    end
    check("beats_done", beats, nbeats);
    check("done_vld", output_vld, 1'b0);
    check("done_state", state, 2'b11);
    check("done_stop", stop, 1'b1);
    check("no_extra_accept", extra_ready, 1'b0);
    input_vld    = 1'b0;
    output_ready = 1'b0;
    tick();
    check("done_hold", state, 2'b11);
    start = 1'b0;
    tick();
    check("back_idle", state, 2'b00);
    check("stop_clear", stop, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (12) tick();
    check("rst_state", state, 2'b00);
    check("rst_in_rdy", input_ready, 1'b0);
    check("rst_vld", output_vld, 1'b0);
    check("rst_dout", interface_out, '0);
    check("rst_stop", stop, 1'b0);
    check("rst_clamped", clamped, 1'b0);

    run_pass(3, 3, 0, 0);
    run_pass(2, 0, 1, 0);

    cfg_len = '0;
    start   = 1'b1;
    repeat (4) tick();
    check("zero_len_state", state, 2'b00);
    check("zero_len_in_rdy", input_ready, 1'b0);
    start = 1'b0;
    tick();

    run_pass(DEPTH + 5, 1, 2, 0);
    run_pass(4, 3, 0, 5);

    repeat (3) tick();
    cfg_len = LW'(3);
    mode    = 2'd2;
    start   = 1'b1;
    rst     = 1'b1;
    tick();
    check("sync_release", state, 2'b00);
    run_pass(3, 2, 2, 0);

    for (int i = 0; i < 3; i++)
      run_pass($urandom_range(1, DEPTH + 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
